fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
Read-side consumer for the asynchronous FIFO, running entirely in the FIFO read-clock domain. It drains bytes from the FIFO read port, packs PACK_BYTES consecutive entries into one wide word, and presents that word downstream on a valid/ready handshake. A flush request emits a partial word with a lane-keep mask. The block never issues a read while the FIFO is empty, so the FIFO read_error flag should never fire.

Parameters:
WIDTH, 8, FIFO entry width in bits; must match the FIFO's WIDTH.
PACK_BYTES, 4, FIFO entries per output word; legal values are 2 to 8.

Ports:
rd_clk  input  1  single clock; same clock as the FIFO read side; all logic on its rising edge.
rst  input  1  synchronous active-low reset: 0 = reset, sampled on the rd_clk rising edge.
empty  input  1  FIFO empty flag.
read_error  input  1  FIFO read_error flag.
read_data  input  WIDTH  FIFO read data; valid in the cycle after the edge that sampled read_en=1.
read_en  output  1  FIFO read strobe.
flush  input  1  single-cycle request to emit the pending partial word.
out_data  output  WIDTH*PACK_BYTES  packed word.
out_keep  output  PACK_BYTES  per-entry lane-valid mask.
out_valid  output  1  out_data and out_keep are valid.
out_ready  input  1  downstream accepts the word when out_valid=1 and out_ready=1 at a clock edge.
flush_done  output  1  one-cycle pulse when a flush completes.
busy  output  1  high when cnt!=0, pend=1, out_valid=1 or state!=RUN.
err_sticky  output  1  set when read_error=1 is sampled; cleared only by reset.

Behaviour:
- Reset values: all outputs 0. Internal state: cnt=0, pend=0, state=RUN, assembly register=0. Any in-flight byte is discarded. Reset mid-operation takes effect on the next edge and has priority over every other event.
- Internal registers: cnt (0..PACK_BYTES) counts bytes held in the assembly register. pend=1 means a read was issued on the previous edge.
- read_en is combinational: read_en = (state==RUN) && !empty && !flush && (cnt+pend < PACK_BYTES). It is never high while empty=1.
- pend is registered from read_en on each edge.
- Capture: when pend=1, read_data is written into lane cnt (bits [cnt*WIDTH +: WIDTH]) and cnt increments.
- Lane order: the first byte goes to lane 0 (LSB). Example: bytes 0x11,0x22,0x33,0x44 pack to 0x44332211.
- Transfer: when cnt==PACK_BYTES and the output slot is free (out_valid=0, or out_valid&&out_ready at this edge):
  - out_data <= assembly register; out_keep <= all ones; out_valid <= 1; cnt <= 0.
  - Otherwise the assembly register holds and reads stall, because the cnt gate blocks them.
- Output handshake: out_data and out_keep stay stable while out_valid=1 and out_ready=0. out_valid drops on the accept edge unless a new transfer occurs on that same edge (back-to-back words allowed).
- State machine:
  - RUN: on flush=1, go to FL_WAIT. No read is issued in the flush cycle.
  - FL_WAIT: wait until pend=0, capturing the last in-flight byte, and until the output slot is free.
    - If cnt>0: on that edge, transfer a partial word with out_keep=(1<<cnt)-1, unused lanes zero, cnt<=0.
    - If cnt==PACK_BYTES: emit a full word instead.
    - If cnt==0: emit no word.
    - Then go to FL_DONE.
  - FL_DONE: flush_done=1 for exactly one cycle, then return to RUN.
- flush while state!=RUN is ignored.
- FIFO becoming empty mid-word: the partial word is held indefinitely until more data arrives or a flush.

Optional Feature:
Macro FIFO_RD_PACK_MSB_FIRST_EN.
- Defined: the first byte goes to lane PACK_BYTES-1 (MSB-first), so 0x11..0x44 pack to 0x11223344. A partial word fills from the top: out_keep = ((1<<cnt)-1) << (PACK_BYTES-cnt), with the low lanes zero.
- Undefined: LSB-first ordering as described under Behaviour.

Test Plan:
- Reset: hold rst=0 for 3 cycles with empty=0 -> read_en=0, out_valid=0, busy=0, err_sticky=0.
- FIFO preloaded with 0x11..0x88, out_ready=1 -> two words: 0x44332211 then 0x88776655, out_keep=4'hF each; read_en never high while empty=1; total of 8 reads.
- Backpressure: 12 bytes loaded, out_ready=0 for 20 cycles -> out_valid=1 with out_data held at 0x44332211; exactly 8 reads issued before the stall; all 3 words delivered in order after out_ready=1.
- Flush after 3 bytes 0xA1,0xA2,0xA3 -> out_data=0x00A3A2A1, out_keep=4'b0111, flush_done pulses once; a flush with cnt=0 -> flush_done pulses and no word is emitted.
- Inject read_error=1 for one cycle -> err_sticky=1 stays set until rst=0.
- Assert rst=0 while pend=1 and cnt=2 -> after the edge, cnt=0 and out_valid=0; the next packed word starts with the next FIFO byte.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// Bundle of the FIFO read-port signals and the packed-word output stream of fifo_rd_packer.
// The master modport is the packer's view; the slave modport is the FIFO/downstream side.
interface fifo_rd_packer_if #(
  parameter int WIDTH      = 8,
  parameter int PACK_BYTES = 4
);
  logic                          empty;
  logic                          read_error;
  logic [WIDTH-1:0]              read_data;
  logic                          read_en;
  logic                          flush;
  logic [WIDTH*PACK_BYTES-1:0]   out_data;
  logic [PACK_BYTES-1:0]         out_keep;
  logic                          out_valid;
  logic                          out_ready;
  logic                          flush_done;
  logic                          busy;
  logic                          err_sticky;

  modport master (
    input  empty, read_error, read_data, flush, out_ready,
    output read_en, out_data, out_keep, out_valid, flush_done, busy, err_sticky
  );

  modport slave (
    output empty, read_error, read_data, flush, out_ready,
    input  read_en, out_data, out_keep, out_valid, flush_done, busy, err_sticky
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Drains FIFO entries, packs PACK_BYTES of them into one word with a lane-keep mask, flush support.
// Define FIFO_RD_PACK_MSB_FIRST_EN to place the first entry in the top lane instead of lane 0.
module fifo_rd_packer #(
  parameter int WIDTH      = 8,
  parameter int PACK_BYTES = 4
) (
  input  logic             rd_clk,
  input  logic             rst,
  fifo_rd_packer_if.master bus
);
  localparam int              CW     = $clog2(PACK_BYTES + 1);
  localparam int              OW     = WIDTH * PACK_BYTES;
  localparam logic [CW:0]     PB_EXT = (CW+1)'(PACK_BYTES);
  localparam logic [CW-1:0]   PB_CNT = CW'(PACK_BYTES);

  typedef enum logic [1:0] {RUN, FL_WAIT, FL_DONE} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic                  pend;
  logic [OW-1:0]         asm_p0, asm_next;
  logic [OW-1:0]         out_data_p1, out_data_next;
  logic [PACK_BYTES-1:0] out_keep_p1, out_keep_next;
  logic                  vld_p1, vld_next;
  logic                  err_r;
  logic                  slot_free;
  logic                  do_xfer;
  logic                  read_en_c;
  int                    lane;

  function automatic logic [PACK_BYTES-1:0] keep_mask(input int n);
    logic [PACK_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < PACK_BYTES; i++) begin
`ifdef FIFO_RD_PACK_MSB_FIRST_EN
      m[i] = (i >= PACK_BYTES - n);
`else
      m[i] = (i < n);
`endif
    end
    return m;
  endfunction

  function automatic int lane_of(input int n);
`ifdef FIFO_RD_PACK_MSB_FIRST_EN
    return PACK_BYTES - 1 - n;
`else
    return n;
`endif
  endfunction

  always_comb begin
    slot_free  = !vld_p1 || bus.out_ready;
    state_next = state;
    do_xfer    = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.flush) state_next = FL_WAIT;
        if (cnt == PB_CNT && slot_free) do_xfer = 1'b1;
      end
      FL_WAIT: begin
        // Last in-flight entry must land before the (possibly partial) word leaves.
        if (!pend && slot_free) begin
          state_next = FL_DONE;
          do_xfer    = (cnt != '0);
        end
      end
      FL_DONE: state_next = RUN;
      default: state_next = RUN;
    endcase

    read_en_c = rst && (state == RUN) && !bus.empty && !bus.flush &&
                (({1'b0, cnt} + {{CW{1'b0}}, pend}) < PB_EXT);

    lane     = lane_of(int'(cnt));
    asm_next = asm_p0;
    cnt_next = cnt + {{(CW-1){1'b0}}, pend};
    for (int i = 0; i < PACK_BYTES; i++) begin
      if (pend && lane == i) asm_next[i*WIDTH +: WIDTH] = bus.read_data;
    end

    out_data_next = out_data_p1;
    out_keep_next = out_keep_p1;
    vld_next      = vld_p1 && !bus.out_ready;
    // A transfer never coincides with a capture, since cnt+pend never exceeds PACK_BYTES.
    if (do_xfer) begin
      out_data_next = asm_p0;
      out_keep_next = keep_mask(int'(cnt));
      vld_next      = 1'b1;
      cnt_next      = '0;
      asm_next      = '0;
    end
  end

  // Stage p0: assembly register; stage p1: output slot
  always_ff @(posedge rd_clk) begin
    if (!rst) begin
      state       <= RUN;
      cnt         <= '0;
      pend        <= 1'b0;
      asm_p0      <= '0;
      out_data_p1 <= '0;
      out_keep_p1 <= '0;
      vld_p1      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      pend        <= read_en_c;
      asm_p0      <= asm_next;
      out_data_p1 <= out_data_next;
      out_keep_p1 <= out_keep_next;
      vld_p1      <= vld_next;
      err_r       <= err_r || bus.read_error;
    end
  end

  assign bus.read_en    = read_en_c;
  assign bus.out_data   = out_data_p1;
  assign bus.out_keep   = out_keep_p1;
  assign bus.out_valid  = vld_p1;
  assign bus.flush_done = (state == FL_DONE);
  assign bus.busy       = (cnt != '0) || pend || vld_p1 || (state != RUN);
  assign bus.err_sticky = err_r;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (default LSB-first build) with a behavioural FIFO read port.
module tb_fifo_rd_packer;
  localparam int WIDTH = 8;
  localparam int PB    = 4;

  logic rd_clk = 1'b0;
  logic rst;

  fifo_rd_packer_if #(.WIDTH(WIDTH), .PACK_BYTES(PB)) ifc();

  fifo_rd_packer #(.WIDTH(WIDTH), .PACK_BYTES(PB)) dut (
    .rd_clk (rd_clk),
    .rst    (rst),
    .bus    (ifc)
  );

  always #5 rd_clk = ~rd_clk;

  logic [7:0]  fifo_q[$];
  logic [31:0] got_d[$];
  logic [3:0]  got_k[$];
  int checks     = 0;
  int errors     = 0;
  int rd_count   = 0;
  int fd_count   = 0;
  int empty_viol = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    ifc.empty = 1'b0;
  endtask

  // Sample outputs on the falling edge, then model the FIFO read port just after the rising edge.
  task automatic step();
    logic re;
    @(negedge rd_clk);
    re = ifc.read_en;
    if (re && ifc.empty) empty_viol++;
    if (ifc.out_valid && ifc.out_ready) begin
      got_d.push_back(ifc.out_data);
      got_k.push_back(ifc.out_keep);
    end
    if (ifc.flush_done) fd_count++;
    @(posedge rd_clk);
    #1;
    if (re) begin
      rd_count++;
      if (fifo_q.size() > 0) ifc.read_data = fifo_q.pop_front();
      ifc.empty = (fifo_q.size() == 0);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    if (i < got_d.size()) return got_d[i];
    return 'x;
  endfunction

  function automatic logic [3:0] keep_at(input int i);
    if (i < got_k.size()) return got_k[i];
    return 'x;
  endfunction

  task automatic run_words(input int k, input int budget);
    for (int i = 0; i < budget && got_d.size() < k; i++) step();
    chk("word_count", 64'(got_d.size()), 64'(k));
  endtask

  task automatic clear_log();
    got_d.delete();
    got_k.delete();
    fd_count = 0;
    rd_count = 0;
  endtask

  initial begin
    rst            = 1'b0;
    ifc.empty      = 1'b1;
    ifc.read_error = 1'b0;
    ifc.read_data  = '0;
    ifc.flush      = 1'b0;
    ifc.out_ready  = 1'b1;

    // Reset held with data available
    for (int b = 1; b <= 8; b++) push(8'(b * 8'h11));
    for (int i = 0; i < 3; i++) step();
    chk("rst_read_en",    64'(ifc.read_en),    64'd0);
    chk("rst_out_valid",  64'(ifc.out_valid),  64'd0);
    chk("rst_busy",       64'(ifc.busy),       64'd0);
    chk("rst_err_sticky", 64'(ifc.err_sticky), 64'd0);
    chk("rst_out_keep",   64'(ifc.out_keep),   64'd0);
    chk("rst_flush_done", 64'(ifc.flush_done), 64'd0);
    chk("rst_reads",      64'(rd_count),       64'd0);

    // Two full words streaming
    rst = 1'b1;
    clear_log();
    run_words(2, 40);
    for (int i = 0; i < 4; i++) step();
    chk("stream_w0",    64'(word_at(0)), 64'h44332211);
    chk("stream_k0",    64'(keep_at(0)), 64'hF);
    chk("stream_w1",    64'(word_at(1)), 64'h88776655);
    chk("stream_k1",    64'(keep_at(1)), 64'hF);
    chk("stream_reads", 64'(rd_count),   64'd8);
    chk("stream_busy",  64'(ifc.busy),   64'd0);

    // Backpressure: 12 entries, downstream stalled
    clear_log();
    ifc.out_ready = 1'b0;
    for (int b = 1; b <= 12; b++) push(8'(b * 8'h11));
    for (int i = 0; i < 20; i++) step();
    chk("bp_out_valid", 64'(ifc.out_valid), 64'd1);
    chk("bp_out_data",  64'(ifc.out_data),  64'h44332211);
    chk("bp_reads",     64'(rd_count),      64'd8);
    chk("bp_fifo_left", 64'(fifo_q.size()), 64'd4);
    chk("bp_no_accept", 64'(got_d.size()),  64'd0);
    for (int i = 0; i < 5; i++) step();
    chk("bp_hold_data", 64'(ifc.out_data),  64'h44332211);
    chk("bp_hold_read", 64'(rd_count),      64'd8);
    ifc.out_ready = 1'b1;
    run_words(3, 40);
    chk("bp_w0", 64'(word_at(0)), 64'h44332211);
    chk("bp_w1", 64'(word_at(1)), 64'h88776655);
    chk("bp_w2", 64'(word_at(2)), 64'hCCBBAA99);
    chk("bp_reads_total", 64'(rd_count), 64'd12);

    // Partial word via flush
    for (int i = 0; i < 4; i++) step();
    clear_log();
    push(8'hA1); push(8'hA2); push(8'hA3);
    for (int i = 0; i < 8; i++) step();
    chk("fl_pending_busy", 64'(ifc.busy),     64'd1);
    chk("fl_no_word_yet",  64'(got_d.size()), 64'd0);
    ifc.flush = 1'b1;
    step();
    ifc.flush = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("fl_words",   64'(got_d.size()), 64'd1);
    chk("fl_data",    64'(word_at(0)),   64'h00A3A2A1);
    chk("fl_keep",    64'(keep_at(0)),   64'b0111);
    chk("fl_done",    64'(fd_count),     64'd1);
    chk("fl_busy",    64'(ifc.busy),     64'd0);

    // Flush with nothing pending
    clear_log();
    ifc.flush = 1'b1;
    step();
    ifc.flush = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("fl0_done",  64'(fd_count),     64'd1);
    chk("fl0_words", 64'(got_d.size()), 64'd0);

    // Sticky read error
    ifc.read_error = 1'b1;
    step();
    ifc.read_error = 1'b0;
    step();
    chk("err_set", 64'(ifc.err_sticky), 64'd1);
    for (int i = 0; i < 3; i++) step();
    chk("err_hold", 64'(ifc.err_sticky), 64'd1);
    rst = 1'b0;
    step();
    chk("err_clear", 64'(ifc.err_sticky), 64'd0);
    rst = 1'b1;
    step();

    // Reset with cnt=2 and one read in flight
    clear_log();
    for (int b = 1; b <= 8; b++) push(8'hB0 + 8'(b));
    for (int i = 0; i < 3; i++) step();
    chk("mid_reads", 64'(rd_count), 64'd3);
    chk("mid_busy",  64'(ifc.busy), 64'd1);
    rst = 1'b0;
    step();
    chk("mid_rst_busy",  64'(ifc.busy),      64'd0);
    chk("mid_rst_valid", 64'(ifc.out_valid), 64'd0);
    rst = 1'b1;
    run_words(1, 30);
    chk("mid_w0", 64'(word_at(0)), 64'hB7B6B5B4);
    for (int i = 0; i < 4; i++) step();
    ifc.flush = 1'b1;
    step();
    ifc.flush = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("mid_tail_w",   64'(word_at(1)), 64'h000000B8);
    chk("mid_tail_k",   64'(keep_at(1)), 64'b0001);
    chk("no_empty_read", 64'(empty_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
